// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Optional even-parity trailer bit is enabled by defining PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_word;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             din_head;
    logic             next_head;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_bit;
`endif

    // Rotating rather than zero-filling keeps every register bit live; only the head bit is ever observed.
    assign shift_word = MSB_FIRST ? {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]}
                                  : {shift_reg[0], shift_reg[WIDTH-1:1]};
    assign din_head   = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_head  = MSB_FIRST ? shift_word[WIDTH-1] : shift_word[0];

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        case (state)
            IDLE:  din_ready = 1'b1;
            SHIFT: begin
                if (cnt == LAST) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_next = PARITY;
`else
                    din_ready  = 1'b1;
                    state_next = IDLE;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                din_ready  = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
        // din_ready never looks at din_valid, so this cannot form a combinational loop with the source.
        accept = din_valid && din_ready;
        if (accept) state_next = SHIFT;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // NOTE: the shift register is reset like any control flop so an aborted frame leaves no stale data behind.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg  <= '0;
            cnt        <= '0;
            q          <= IDLE_LEVEL;
            q_valid    <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg  <= din;
            cnt        <= '0;
            q          <= din_head;
            q_valid    <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_bit <= ^din;
`endif
        end else if (state == SHIFT && cnt != LAST) begin
            shift_reg <= shift_word;
            cnt       <= cnt + 1'b1;
            q         <= next_head;
`ifdef PISO_SERIALIZER_PARITY_EN
        end else if (state == SHIFT) begin
            q <= parity_bit;
`endif
        end else begin
            q       <= IDLE_LEVEL;
            q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=4, IDLE_LEVEL=0); one MSB-first and one LSB-first instance.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] din, din_l;
    logic         din_valid, din_valid_l;
    logic         din_ready, q, q_valid, busy;
    logic         din_ready_l, q_l, q_valid_l, busy_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .q(q), .q_valid(q_valid), .busy(busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
        .q(q_l), .q_valid(q_valid_l), .busy(busy_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_msb: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
        checks++;
        if ({q_l, q_valid_l, busy_l, din_ready_l} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_lsb: q/q_valid/busy/din_ready=%b expected 0001", {q_l, q_valid_l, busy_l, din_ready_l});
        end
        rstn = 1'b1;
        step();
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL idle_after_reset: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
    endtask

    task automatic test_msb_frame();
        logic [L-1:0] exp;
`ifdef PISO_SERIALIZER_PARITY_EN
        exp = 5'b10111;
`else
        exp = 4'b1011;
`endif
        din = 4'b1011;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din = 4'b0100;
        for (int k = 0; k < L; k++) begin
            checks++;
            if ({q, q_valid, busy, din_ready} !== {exp[L-1-k], 2'b11, (k == L - 1)}) begin
                failures++;
                $display("FAIL msb_frame cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q, q_valid, busy, din_ready}, {exp[L-1-k], 2'b11, (k == L - 1)});
            end
            step();
        end
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL msb_frame_end: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
    endtask

    task automatic test_lsb_frame();
        logic [L-1:0] exp;
`ifdef PISO_SERIALIZER_PARITY_EN
        exp = 5'b11011;
`else
        exp = 4'b1101;
`endif
        din_l = 4'b1011;
        din_valid_l = 1'b1;
        step();
        din_valid_l = 1'b0;
        din_l = 4'b0000;
        for (int k = 0; k < L; k++) begin
            checks++;
            if ({q_l, q_valid_l, busy_l, din_ready_l} !== {exp[L-1-k], 2'b11, (k == L - 1)}) begin
                failures++;
                $display("FAIL lsb_frame cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q_l, q_valid_l, busy_l, din_ready_l}, {exp[L-1-k], 2'b11, (k == L - 1)});
            end
            step();
        end
        checks++;
        if ({q_l, q_valid_l, busy_l, din_ready_l} !== 4'b0001) begin
            failures++;
            $display("FAIL lsb_frame_end: q/q_valid/busy/din_ready=%b expected 0001", {q_l, q_valid_l, busy_l, din_ready_l});
        end
    endtask

    task automatic test_back_to_back();
        logic [2*L-1:0] exp;
`ifdef PISO_SERIALIZER_PARITY_EN
        exp = 10'b10100_01010;
`else
        exp = 8'b1010_0101;
`endif
        din = 4'hA;
        din_valid = 1'b1;
        step();
        for (int k = 0; k < 2 * L; k++) begin
            if (k == L - 1) din = 4'h5;
            if (k == 2 * L - 1) din_valid = 1'b0;
            checks++;
            if ({q, q_valid, busy, din_ready} !== {exp[2*L-1-k], 2'b11, (k == L - 1 || k == 2 * L - 1)}) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q, q_valid, busy, din_ready}, {exp[2*L-1-k], 2'b11, (k == L - 1 || k == 2 * L - 1)});
            end
            step();
        end
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL back_to_back_end: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [2*L-1:0] exp;
`ifdef PISO_SERIALIZER_PARITY_EN
        exp = 10'b00110_11110;
`else
        exp = 8'b0011_1111;
`endif
        din = 4'h3;
        din_valid = 1'b1;
        step();
        din = 4'hF;
        for (int k = 0; k < 2 * L; k++) begin
            if (k == L) din_valid = 1'b0;
            checks++;
            if ({q, q_valid, busy, din_ready} !== {exp[2*L-1-k], 2'b11, (k == L - 1 || k == 2 * L - 1)}) begin
                failures++;
                $display("FAIL backpressure cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q, q_valid, busy, din_ready}, {exp[2*L-1-k], 2'b11, (k == L - 1 || k == 2 * L - 1)});
            end
            step();
        end
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL backpressure_end: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [L-1:0] exp;
`ifdef PISO_SERIALIZER_PARITY_EN
        exp = 5'b01100;
`else
        exp = 4'b0110;
`endif
        din = 4'b1100;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        checks++;
        if ({q, q_valid, busy} !== 3'b111) begin
            failures++;
            $display("FAIL mid_frame_bit2: q/q_valid/busy=%b expected 111", {q, q_valid, busy});
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL async_abort: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
        #2 rstn = 1'b1;
        step();
        din = 4'b0110;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int k = 0; k < L; k++) begin
            checks++;
            if ({q, q_valid, busy, din_ready} !== {exp[L-1-k], 2'b11, (k == L - 1)}) begin
                failures++;
                $display("FAIL after_reset_frame cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q, q_valid, busy, din_ready}, {exp[L-1-k], 2'b11, (k == L - 1)});
            end
            step();
        end
        checks++;
        if ({q, q_valid, busy, din_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL after_reset_end: q/q_valid/busy/din_ready=%b expected 0001", {q, q_valid, busy, din_ready});
        end
    endtask

`ifdef PISO_SERIALIZER_PARITY_EN
    task automatic test_parity_zero();
        logic [L-1:0] exp;
        exp = 5'b10010;
        din = 4'b1001;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int k = 0; k < L; k++) begin
            checks++;
            if ({q, q_valid, busy, din_ready} !== {exp[L-1-k], 2'b11, (k == L - 1)}) begin
                failures++;
                $display("FAIL parity_zero cycle %0d: q/q_valid/busy/din_ready=%b expected %b",
                         k + 1, {q, q_valid, busy, din_ready}, {exp[L-1-k], 2'b11, (k == L - 1)});
            end
            step();
        end
        checks++;
        if ({q, q_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL parity_zero_end: q/q_valid/busy=%b expected 000", {q, q_valid, busy});
        end
    endtask
`endif

    initial begin
        din         = '0;
        din_valid   = 1'b0;
        din_l       = '0;
        din_valid_l = 1'b0;
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
`ifdef PISO_SERIALIZER_PARITY_EN
        test_parity_zero();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

- Parallel-in, serial-out transmitter.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a per-bit valid strobe.
- Acts as the source end of the serial bit pipelines in this lab set: `q` drives the `d` input of a serial delay pipeline or a serial-to-parallel capture block.

## Interface
Parameters:
- `WIDTH`, 4: data word width; legal range 2..32.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `q` whenever `q_valid` is 0.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `din`, input, WIDTH: parallel word; sampled only on the accepting edge.
- `din_valid`, input, 1: `din` holds a word to send.
- `din_ready`, output, 1: block can accept a word this cycle.
- `q`, output, 1: serial data, registered.
- `q_valid`, output, 1: `q` carries a frame bit this cycle, registered.
- `busy`, output, 1: a frame is in progress (state is not IDLE).

## Operation
- **States:** IDLE, SHIFT, and PARITY (PARITY exists only when configured in).
- **Registers:**
  - shift register, WIDTH bits;
  - bit counter, `$clog2(WIDTH)` bits, counting 0..WIDTH-1; it never wraps past WIDTH-1.
- **Accept:** a word is accepted on a rising edge where `din_valid && din_ready`. The word is copied into the shift register, the counter is cleared, and the state goes to SHIFT.
- **`din_ready`:** driven combinationally from state and counter only, never from `din_valid`. It is 1 when:
  - the state is IDLE, or
  - the block is in the final cycle of a frame (last data bit with no parity, or the PARITY cycle).
- **SHIFT:** `q` shows the current bit (MSB or LSB per `MSB_FIRST`) and `q_valid`=1. Each cycle the register shifts and the counter increments.
- **End of last data bit (counter = WIDTH-1):**
  - parity configured: go to PARITY;
  - otherwise, if a new word is accepted, go to SHIFT;
  - otherwise go to IDLE.
- **PARITY:** one cycle, `q_valid`=1. Then go to SHIFT if a new word is accepted, else IDLE.
- **Back-to-back:** a word accepted in the final cycle starts its first bit on the very next cycle. There is no gap and `q_valid` stays high.
- **`din` stability:** changes to `din` after the accepting edge have no effect on the frame in flight.
- **`din_valid` without `din_ready`:** ignored. The word is not latched, and the caller holds it.
- **Reset:**
  - Asserting `rstn` low mid-frame aborts the frame immediately and asynchronously. The partial frame is discarded with no completion.
  - Reset values: state IDLE, `q`=`IDLE_LEVEL`, `q_valid`=0, `busy`=0, `din_ready`=1, counter 0, shift register 0.

## Timing
- **Latency:** the first bit of a frame is on `q` in the cycle after the accepting edge.
- **Frame length:**
  - WIDTH cycles of `q_valid`=1 without parity;
  - WIDTH+1 cycles with parity.
- **Throughput:** one bit per clock. Continuous streaming is possible when the source keeps `din_valid` high.
- **`busy`:** rises in the same cycle as the first `q_valid` and falls together with `q_valid` when the state returns to IDLE.
- **Outputs:** `q`, `q_valid` and `busy` are registered; `din_ready` is combinational.

## Configuration
- **Macro:** `PISO_SERIALIZER_PARITY_EN`.
- **Defined:**
  - After the last data bit, one extra `q_valid` bit is sent carrying even parity. That bit is the XOR of all WIDTH data bits, so the total frame has an even count of ones.
  - `din_ready` asserts in the PARITY cycle instead of the last data cycle.
- **Undefined:** the PARITY state and its logic are absent; frames are exactly WIDTH bits.

## Test plan
All scenarios use WIDTH=4 and `IDLE_LEVEL`=0 unless stated.
- **Single MSB-first frame:** `MSB_FIRST`=1, `din`=4'b1011 with one-cycle `din_valid` → `q`=1,0,1,1 in cycles 1–4 after the accepting edge. `q_valid` and `busy` are 1 for exactly 4 cycles, then `q`=0 and `q_valid`=0.
- **LSB-first frame:** `MSB_FIRST`=0, `din`=4'b1011 → `q`=1,1,0,1.
- **Back-to-back:** `din_valid` held high with 4'hA, then 4'h5 presented on the cycle `din_ready` reasserts → 8 contiguous valid bits 1,0,1,0,0,1,0,1. `q_valid` never drops, and `din_ready` is high only in IDLE and in cycles 4 and 8.
- **Backpressure:** `din_valid`=1 with 4'hF while mid-frame (`din_ready`=0) → no latch. Then 4'hF is accepted at the frame's final cycle and sent next.
- **Reset mid-frame:** `rstn`=0 asserted between clock edges during bit 2 → `q`=0, `q_valid`=0, `busy`=0, `din_ready`=1 without waiting for a clock edge. After release, a new frame 4'b0110 is sent correctly from bit 0.
- **Parity (macro defined):** `din`=4'b1011 → `q`=1,0,1,1,1 over 5 valid cycles. `din`=4'b1001 → parity bit 0.
